// File: rtl/fila_pkg.sv
// Shared types and widths for the FILA byte-queue path (deserializer, queue, serializer).
// No logic here: constants, the serializer state encoding and a width helper.
// Anything that changes a width here changes every block that imports it.
package fila_pkg;

  localparam int FILA_DATA_WIDTH = 8;
  localparam int FILA_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } ser_state_t;

  // Counter width able to index every bit of a frame; never collapses to zero bits.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; emits LSB or MSB first.
// Latency: loaded word visible on o_ser the cycle after i_load.
// Backpressure: holds its contents whenever i_shift is low.
module piso_shift_reg
  import fila_pkg::*;
#(
  parameter int DATA_WIDTH = FILA_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic                  o_ser
);

  logic [DATA_WIDTH-1:0] r_shreg;

  // Load has priority over shift; the vacated end fills with zeros.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_dat;
    end else if (i_shift) begin
      if (MSB_FIRST) begin
        r_shreg <= r_shreg << 1;
      end else begin
        r_shreg <= r_shreg >> 1;
      end
    end
  end

  assign o_ser = MSB_FIRST ? r_shreg[DATA_WIDTH-1] : r_shreg[0];

endmodule

// File: rtl/fila_serializer.sv
// Drains the FILA byte queue: pops one byte at a time and shifts it out bit-serially.
// Latency: occupancy seen in IDLE at cycle k -> pop k+1, capture k+2, first bit k+3.
// Backpressure: ready_in low freezes the current bit and counter; no pop while stalled.
module fila_serializer
  import fila_pkg::*;
#(
  parameter int DATA_WIDTH = FILA_DATA_WIDTH,
  parameter int LEN_WIDTH  = FILA_LEN_WIDTH,
  parameter int MIN_LEN    = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clock_10KHz,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  len_in,
  output logic                  dequeue_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready_in,
  output logic                  bit_out,
  output logic                  bit_valid_out,
  output logic                  frame_start_out,
  output logic                  busy_out,
  output logic [7:0]            byte_count_out
);

  localparam int                   CNT_W     = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LEN_WIDTH-1:0] MIN_LEN_L = LEN_WIDTH'(MIN_LEN);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic             r_dequeue;
  logic             r_bit_valid;
  logic             r_frame_start;
  logic             r_busy;
  logic [7:0]       r_byte_cnt;

  logic             w_len_ok;
  logic             w_xfer;
  logic             w_last;
  logic             w_load;
  logic             w_shift;
  logic             w_byte_done;
  logic             w_ser;

  // Occupancy is only acted upon in IDLE and on the last-bit transfer, so a
  // stale len_in during POP/LOAD can never trigger a second pop.
  assign w_len_ok = (len_in >= MIN_LEN_L);
  assign w_xfer   = r_bit_valid && ready_in;
  assign w_last   = (r_bit_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, bit counter and datapath enables.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_byte_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_len_ok) begin
          w_state_nxt = POP;
        end
      end
      POP: begin
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_load        = 1'b1;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = SHIFT;
      end
      SHIFT: begin
        if (w_xfer) begin
          w_shift = 1'b1;
          if (w_last) begin
            w_byte_done   = 1'b1;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = w_len_ok ? POP : IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_dequeue     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_byte_cnt    <= 8'd0;
    end else begin
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_dequeue     <= (w_state_nxt == POP);
      r_bit_valid   <= (w_state_nxt == SHIFT);
      r_frame_start <= (w_state_nxt == SHIFT) && (w_bit_cnt_nxt == '0);
      r_busy        <= (w_state_nxt != IDLE);
      if (w_byte_done) begin
        r_byte_cnt <= r_byte_cnt + 8'd1;
      end
    end
  end

  piso_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_piso (
    .i_clk   (clock_10KHz),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_dat   (data_in),
    .o_ser   (w_ser)
  );

  assign dequeue_out     = r_dequeue;
  assign bit_valid_out   = r_bit_valid;
  assign frame_start_out = r_frame_start;
  assign busy_out        = r_busy;
  assign byte_count_out  = r_byte_cnt;
  assign bit_out         = w_ser;

endmodule

// File: tb/tb_fila_serializer.sv
// Bench for fila_serializer: an LSB-first and an MSB-first instance share one
// emulated byte queue; expected bit streams are queued when bytes are enqueued.
module tb_fila_serializer;
  import fila_pkg::*;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] len_in;
  logic [DW-1:0] data_in;
  logic          ready_in;

  logic       deq_l, bit_l, vld_l, fs_l, busy_l;
  logic [7:0] bc_l;
  logic       deq_m, bit_m, vld_m, fs_m, busy_m;
  logic [7:0] bc_m;

  always #5 clk = ~clk;

  fila_serializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MIN_LEN(1), .MSB_FIRST(1'b0)) u_dut (
    .clock_10KHz(clk), .reset(reset), .len_in(len_in), .dequeue_out(deq_l),
    .data_in(data_in), .ready_in(ready_in), .bit_out(bit_l), .bit_valid_out(vld_l),
    .frame_start_out(fs_l), .busy_out(busy_l), .byte_count_out(bc_l));

  fila_serializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MIN_LEN(1), .MSB_FIRST(1'b1)) u_dut_msb (
    .clock_10KHz(clk), .reset(reset), .len_in(len_in), .dequeue_out(deq_m),
    .data_in(data_in), .ready_in(ready_in), .bit_out(bit_m), .bit_valid_out(vld_m),
    .frame_start_out(fs_m), .busy_out(busy_m), .byte_count_out(bc_m));

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t       exp_l[$];
  exp_t       exp_m[$];
  logic [7:0] src_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         rdy_mode   = 0;   // 0 high, 1 toggle, 2 random, 3 held low
  logic [7:0] exp_cnt    = 8'd0;

  // Monitor state, index 0 = LSB-first instance, 1 = MSB-first instance.
  logic       hold[2];
  logic       hb[2];
  logic       hf[2];
  logic       cnt_pend[2];
  logic [7:0] mcnt[2];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void fail(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    for (int i = 0; i < DW; i++) begin
      exp_l.push_back({b[i], (i == 0), (i == DW - 1)});
      exp_m.push_back({b[DW-1-i], (i == 0), (i == DW - 1)});
    end
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Queue emulator and ready driver: pops on the cycle after dequeue_out,
  // otherwise presents junk on data_in.
  initial begin
    logic deq_pend;
    deq_pend = 1'b0;
    len_in   = '0;
    data_in  = '0;
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (reset) deq_pend = 1'b0;
      if (deq_pend) begin
        deq_pend = 1'b0;
        if (src_q.size() == 0) begin
          fail("extra_pop");
          data_in = 8'($urandom);
        end else begin
          data_in = src_q.pop_front();
        end
      end else begin
        data_in = 8'($urandom);
      end
      if (!reset && deq_l) deq_pend = 1'b1;
      len_in = (src_q.size() > 15) ? 4'd15 : 4'(src_q.size());
      case (rdy_mode)
        0: ready_in = 1'b1;
        1: ready_in = ~ready_in;
        2: ready_in = ($urandom_range(0, 3) != 0);
        default: ready_in = 1'b0;
      endcase
    end
  end

  task automatic mon(input int d, input logic vld, input logic b, input logic fs,
                     input logic busy, input logic [7:0] bc);
    exp_t  e;
    string tag;
    tag = (d == 0) ? "lsb" : "msb";
    if (cnt_pend[d]) begin
      check({tag, "_byte_count"}, 32'(bc), 32'(mcnt[d]));
      cnt_pend[d] = 1'b0;
    end
    if (hold[d]) begin
      check({tag, "_stall_valid"}, 32'(vld), 32'd1);
      check({tag, "_stall_bit"}, 32'(b), 32'(hb[d]));
      check({tag, "_stall_fs"}, 32'(fs), 32'(hf[d]));
      hold[d] = 1'b0;
    end
    if (!vld) check({tag, "_fs_without_valid"}, 32'(fs), 32'd0);
    else      check({tag, "_busy_with_valid"}, 32'(busy), 32'd1);
    if (vld && ready_in) begin
      if ((d == 0 && exp_l.size() == 0) || (d == 1 && exp_m.size() == 0)) begin
        fail({tag, "_unexpected_bit"});
      end else begin
        e = (d == 0) ? exp_l.pop_front() : exp_m.pop_front();
        check({tag, "_bit"}, 32'(b), 32'(e.b));
        check({tag, "_frame_start"}, 32'(fs), 32'(e.first));
        if (e.last) begin
          mcnt[d]     = mcnt[d] + 8'd1;
          cnt_pend[d] = 1'b1;
        end
      end
    end else if (vld) begin
      hold[d] = 1'b1;
      hb[d]   = b;
      hf[d]   = fs;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic rst_q;
    rst_q = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hold[d] = 1'b0; hb[d] = 1'b0; hf[d] = 1'b0; cnt_pend[d] = 1'b0; mcnt[d] = 8'd0;
    end
    forever begin
      @(negedge clk);
      if (rst_q) begin
        check("reset_outputs_lsb", 32'({deq_l, bit_l, vld_l, fs_l, busy_l, bc_l}), 32'd0);
        check("reset_outputs_msb", 32'({deq_m, bit_m, vld_m, fs_m, busy_m, bc_m}), 32'd0);
        exp_l.delete();
        exp_m.delete();
        for (int d = 0; d < 2; d++) begin
          hold[d] = 1'b0; cnt_pend[d] = 1'b0; mcnt[d] = 8'd0;
        end
      end else begin
        mon(0, vld_l, bit_l, fs_l, busy_l, bc_l);
        mon(1, vld_m, bit_m, fs_m, busy_m, bc_m);
      end
      rst_q = reset;
    end
  end

  // Cycle-exact check of n back-to-back frames with ready held high; t counts
  // cycles from the one in which len_in first becomes non-zero.
  task automatic check_burst(input int n);
    logic ed, ev, ef;
    for (int t = 0; t <= 10 * n + 2; t++) begin
      ed = (t >= 1) && ((t - 1) % 10 == 0) && ((t - 1) / 10 < n);
      ev = (t >= 3) && ((t - 3) % 10 < 8) && ((t - 3) / 10 < n);
      ef = ev && ((t - 3) % 10 == 0);
      tick(1);
      check("burst_dequeue_lsb", 32'(deq_l), 32'(ed));
      check("burst_dequeue_msb", 32'(deq_m), 32'(ed));
      check("burst_valid_lsb", 32'(vld_l), 32'(ev));
      check("burst_valid_msb", 32'(vld_m), 32'(ev));
      check("burst_frame_start", 32'(fs_l), 32'(ef));
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_l.size() != 0 || exp_m.size() != 0 || src_q.size() != 0 ||
                          busy_l || busy_m)) begin
      tick(1);
      i++;
    end
    if (i >= budget) fail("drain_timeout");
    tick(2);
    check("drained_byte_count_lsb", 32'(bc_l), 32'(exp_cnt));
    check("drained_byte_count_msb", 32'(bc_m), 32'(exp_cnt));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    src_q.delete();
    exp_cnt = 8'd0;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Idle with an empty queue: nothing may happen.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (deq_l || deq_m || vld_l || busy_l || bc_l != 0) n++;
    end
    check("idle_activity_cycles", 32'(n), 32'd0);

    // Single frame, exact latency and bit order.
    push_byte(8'hA5);
    check_burst(1);
    check("single_byte_count", 32'(bc_l), 32'd1);

    // Three queued bytes: back-to-back frames with a two-cycle gap.
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    check_burst(3);
    check("burst_byte_count", 32'(bc_l), 32'd4);

    // Alternating ready: eight transfers spread over sixteen cycles.
    rdy_mode = 1;
    push_byte(8'h81);
    for (int i = 0; i < 10 && !vld_m; i++) tick(1);
    if (!vld_m) fail("toggle_first_valid_timeout");
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (vld_m && ready_in) n++;
      tick(1);
    end
    check("toggle_transfers_in_16", 32'(n), 32'd8);
    rdy_mode = 0;
    drain(100);

    // Ready held low: the frame stalls and no further pop occurs.
    rdy_mode = 3;
    push_byte(8'h3C);
    push_byte(8'hC3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (deq_l) n++;
    end
    check("stall_pop_count", 32'(n), 32'd1);
    check("stall_still_valid", 32'(vld_l), 32'd1);
    rdy_mode = 0;
    drain(100);

    // Reset on the fourth bit of a frame: no resumption afterwards.
    push_byte(8'hF0);
    for (int i = 0; i < 10 && !vld_l; i++) tick(1);
    if (!vld_l) fail("midreset_first_valid_timeout");
    tick(3);
    check("midreset_on_bit3_valid", 32'(vld_l), 32'd1);
    reset = 1'b1;
    src_q.delete();
    exp_cnt = 8'd0;
    tick(1);
    reset = 1'b0;
    check("midreset_valid", 32'(vld_l), 32'd0);
    check("midreset_busy", 32'(busy_l), 32'd0);
    check("midreset_byte_count", 32'(bc_l), 32'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (vld_l || deq_l || vld_m) n++;
    end
    check("midreset_no_resume", 32'(n), 32'd0);

    // Random traffic, including a burst that fills the occupancy field.
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) push_byte(8'($urandom));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) push_byte(8'($urandom));
      tick(1);
    end
    drain(2000);
    rdy_mode = 0;

    // 255 frames, then one more wraps the frame counter to zero.
    do_reset(1);
    tick(1);
    for (int i = 0; i < 255; i++) push_byte(8'($urandom));
    drain(4000);
    check("count_at_255", 32'(bc_l), 32'd255);
    push_byte(8'h5A);
    drain(100);
    check("count_wrap_lsb", 32'(bc_l), 32'd0);
    check("count_wrap_msb", 32'(bc_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
